// File: rtl/mem_initiator_pkg.sv
// Shared types for the memory-port initiator: FSM states, access size codes, request error check.
// Combinational helpers only, so there is no latency and no backpressure at this level.
package mem_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Illegal size, misaligned halfword or word, or address past the end of memory.
    function automatic logic req_error(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input logic [31:0] limit);
        return (size == 2'b11)
            || (size == SZ_HALF && addr[0])
            || (size == SZ_WORD && addr[1:0] != 2'b00)
            || (addr >= limit);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane extract with sign/zero extension for loads, and byte/halfword merge into a read word for stores.
// Purely combinational (zero latency); it has no handshake and never applies backpressure.
module mem_lane_align
    import mem_initiator_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        zext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val  = word[{lane, 3'b000} +: 8];
        half_val  = word[{lane[1], 4'b0000} +: 16];
        load_data = word;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{byte_val[7] & ~zext}}, byte_val};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{half_val[15] & ~zext}}, half_val};
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator onto a word-wide memory; sub-word stores are read-modify-write.
// Latency: error 1, load 2, word store 2, sub-word store 3 cycles; reqReady stays low until the request retires.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    output logic [31:0] rspData,
    output logic        rspErr,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memData
);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_buf;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic        err_q;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_err = req_error(reqSize, reqAddr, 32'(MEM_BYTES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_buf <= '0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reqValid) begin
                        addr_q  <= reqAddr;
                        wdata_q <= reqWData;
                        size_q  <= reqSize;
                        uns_q   <= reqUnsigned;
                        write_q <= reqWrite;
                        err_q   <= req_err;
                        if (req_err)
                            state <= ST_RESP;
                        else if (!reqWrite || reqSize != SZ_WORD)
                            state <= ST_READ;
                        else
                            state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    word_buf <= memData;
                    state    <= write_q ? ST_WRITE : ST_RESP;
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Loads extract from the buffered word; stores merge into it (a word store ignores the buffer).
    mem_lane_align u_align (
        .word      (word_buf),
        .size      (size_q),
        .lane      (addr_q[1:0]),
        .zext      (uns_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    assign reqReady     = (state == ST_IDLE);
    assign memRead      = (state == ST_READ);
    assign memWrite     = (state == ST_WRITE);
    assign rspValid     = (state == ST_RESP);
    assign rspErr       = rspValid && err_q;
    assign rspData      = (rspValid && !err_q && !write_q) ? load_data : 32'd0;
    assign memAddress   = {addr_q[31:2], 2'b00};
    assign memWriteData = merged;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed vector bench for mem_initiator with a 256-byte little-endian memory model.
// Expected data, latencies and memory-cycle positions are hand-computed in the vector table.
module tb_mem_initiator;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, reqUnsigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWData;
    logic        rspValid, rspErr, memRead, memWrite;
    logic [31:0] rspData, memAddress, memWriteData, memData;

    logic [7:0]  mem [0:255];
    int          applied = 0;
    int          miscompares = 0;
    int          both_hi = 0;

    always #5 clk = ~clk;

    mem_initiator #(.MEM_BYTES(256)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWData(reqWData),
        .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memRead(memRead), .memWrite(memWrite), .memData(memData)
    );

    always_comb
        memData = {mem[{memAddress[7:2], 2'd3}], mem[{memAddress[7:2], 2'd2}],
                   mem[{memAddress[7:2], 2'd1}], mem[{memAddress[7:2], 2'd0}]};

    always @(posedge clk) begin
        if (memWrite) begin
            mem[{memAddress[7:2], 2'd0}] <= memWriteData[7:0];
            mem[{memAddress[7:2], 2'd1}] <= memWriteData[15:8];
            mem[{memAddress[7:2], 2'd2}] <= memWriteData[23:16];
            mem[{memAddress[7:2], 2'd3}] <= memWriteData[31:24];
        end
    end

    always @(negedge clk)
        if (memRead && memWrite) both_hi++;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_data, logic exp_err,
                                int exp_lat, int exp_rd, int exp_wr,
                                logic [31:0] exp_maddr, logic [31:0] exp_wdata);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_maddr = exp_maddr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic preload(input int addr, input logic [31:0] word);
        mem[addr]     <= word[7:0];
        mem[addr + 1] <= word[15:8];
        mem[addr + 2] <= word[23:16];
        mem[addr + 3] <= word[31:24];
    endtask

    function automatic logic [31:0] peek(input int addr);
        return {mem[addr + 3], mem[addr + 2], mem[addr + 1], mem[addr]};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after the response.
    task automatic do_req(input vec_t v, input string tag,
                          output int lat, output int rd_at, output int wr_at,
                          output int nrd, output int nwr, output int rdy_busy,
                          output logic [31:0] data, output logic err,
                          output logic [31:0] maddr_rd, output logic [31:0] maddr_wr,
                          output logic [31:0] wdat);
        lat = -1; rd_at = 0; wr_at = 0; nrd = 0; nwr = 0; rdy_busy = 0;
        data = 'x; err = 1'bx; maddr_rd = 'x; maddr_wr = 'x; wdat = 'x;
        check({tag, " ready_before"}, 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqWrite = v.wr; reqSize = v.sz; reqUnsigned = v.uns;
        reqAddr = v.addr; reqWData = v.wdata;
        @(posedge clk);
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            reqValid = 1'b0;
            if (memRead) begin
                nrd++;
                if (rd_at == 0) begin rd_at = k; maddr_rd = memAddress; end
            end
            if (memWrite) begin
                nwr++;
                if (wr_at == 0) begin wr_at = k; maddr_wr = memAddress; wdat = memWriteData; end
            end
            if (reqReady) rdy_busy++;
            if (rspValid) begin lat = k; data = rspData; err = rspErr; end
        end
        @(negedge clk);
    endtask

    int          lat, rd_at, wr_at, nrd, nwr, rdy_busy;
    logic [31:0] data, maddr_rd, maddr_wr, wdat;
    logic        err;
    logic        wr_seen;
    int          rsp_seen;

    initial begin
        reset = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqUnsigned = 1'b0; reqAddr = '0; reqWData = '0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        #1;
        preload(140, 32'h0000_0052);
        preload(144, 32'h1122_3344);
        preload(160, 32'h1122_3344);
        preload(252, 32'h9A00_0000);
        #1;
        check("rst reqReady", 32'(reqReady), 32'd1);
        check("rst rspValid", 32'(rspValid), 32'd0);
        check("rst rspErr", 32'(rspErr), 32'd0);
        check("rst memRead", 32'(memRead), 32'd0);
        check("rst memWrite", 32'(memWrite), 32'd0);
        check("rst rspData", rspData, 32'd0);
        check("rst memAddress", memAddress, 32'd0);
        check("rst memWriteData", memWriteData, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        //             wr sz uns addr        wdata         exp_data      err lat rd wr maddr  exp_wdata
        vecs.push_back(mk(0, W, 0, 32'd140, 32'h0,        32'h00000052, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(1, W, 0, 32'd140, 32'h80FF7F52, 32'h0,        0, 2, 0, 1, 32'd140, 32'h80FF7F52));
        vecs.push_back(mk(0, B, 0, 32'd141, 32'h0,        32'h0000007F, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(0, B, 0, 32'd142, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(0, B, 1, 32'd142, 32'h0,        32'h000000FF, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(0, H, 0, 32'd142, 32'h0,        32'hFFFF80FF, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(0, H, 1, 32'd142, 32'h0,        32'h000080FF, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(0, B, 0, 32'd143, 32'h0,        32'hFFFFFF80, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(0, H, 0, 32'd140, 32'h0,        32'h00007F52, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(0, W, 0, 32'd140, 32'h0,        32'h80FF7F52, 0, 2, 1, 0, 32'd140, 32'h0));
        vecs.push_back(mk(1, H, 0, 32'd146, 32'h0000BEEF, 32'h0,        0, 3, 1, 2, 32'd144, 32'hBEEF3344));
        vecs.push_back(mk(0, W, 0, 32'd144, 32'h0,        32'hBEEF3344, 0, 2, 1, 0, 32'd144, 32'h0));
        vecs.push_back(mk(1, B, 0, 32'd145, 32'h123456AA, 32'h0,        0, 3, 1, 2, 32'd144, 32'hBEEFAA44));
        vecs.push_back(mk(0, W, 0, 32'd144, 32'h0,        32'hBEEFAA44, 0, 2, 1, 0, 32'd144, 32'h0));
        vecs.push_back(mk(1, W, 0, 32'd148, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 32'd148, 32'hCAFEF00D));
        vecs.push_back(mk(0, W, 0, 32'd148, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 32'd148, 32'h0));
        vecs.push_back(mk(0, W, 0, 32'h8A,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(1, W, 0, 32'd256, 32'h12345678, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, X, 0, 32'd0,   32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, H, 0, 32'h91,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(1, H, 0, 32'h91,  32'h0000FFFF, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, W, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, B, 0, 32'd255, 32'h0,        32'hFFFFFF9A, 0, 2, 1, 0, 32'd252, 32'h0));
        vecs.push_back(mk(0, B, 1, 32'd255, 32'h0,        32'h0000009A, 0, 2, 1, 0, 32'd252, 32'h0));
        vecs.push_back(mk(0, W, 0, 32'd148, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 32'd148, 32'h0));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            do_req(vecs[i], tag, lat, rd_at, wr_at, nrd, nwr, rdy_busy, data, err, maddr_rd, maddr_wr, wdat);
            check({tag, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({tag, " rspData"}, data, vecs[i].exp_data);
            check({tag, " rspErr"}, 32'(err), 32'(vecs[i].exp_err));
            check({tag, " memRead cycle"}, 32'(rd_at), 32'(vecs[i].exp_rd));
            check({tag, " memWrite cycle"}, 32'(wr_at), 32'(vecs[i].exp_wr));
            check({tag, " memRead count"}, 32'(nrd), 32'(vecs[i].exp_rd != 0));
            check({tag, " memWrite count"}, 32'(nwr), 32'(vecs[i].exp_wr != 0));
            check({tag, " reqReady busy"}, 32'(rdy_busy), 32'd0);
            if (vecs[i].exp_rd != 0) check({tag, " read addr"}, maddr_rd, vecs[i].exp_maddr);
            if (vecs[i].exp_wr != 0) begin
                check({tag, " write addr"}, maddr_wr, vecs[i].exp_maddr);
                check({tag, " write data"}, wdat, vecs[i].exp_wdata);
            end
        end
        check("errors left memory 0", peek(0), 32'h0);

        // Reset asserted mid-cycle during the WRITE of a byte store: nothing commits, no response.
        wr_seen = 1'b0;
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = B; reqUnsigned = 1'b0;
        reqAddr = 32'd161; reqWData = 32'h00000055;
        @(posedge clk);
        for (int k = 1; k <= 6 && !wr_seen; k++) begin
            @(negedge clk);
            reqValid = 1'b0;
            if (memWrite) wr_seen = 1'b1;
        end
        check("rstwr reached WRITE", 32'(wr_seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstwr memWrite drop", 32'(memWrite), 32'd0);
        check("rstwr memRead", 32'(memRead), 32'd0);
        check("rstwr reqReady", 32'(reqReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rstwr mem unchanged", peek(160), 32'h11223344);
        reset = 1'b1;
        rsp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rspValid) rsp_seen++;
        end
        check("rstwr no rspValid", 32'(rsp_seen), 32'd0);
        check("rstwr ready after", 32'(reqReady), 32'd1);
        do_req(mk(0, W, 0, 32'd160, 32'h0, 32'h11223344, 0, 2, 1, 0, 32'd160, 32'h0), "post-reset lw",
               lat, rd_at, wr_at, nrd, nwr, rdy_busy, data, err, maddr_rd, maddr_wr, wdat);
        check("post-reset lw latency", 32'(lat), 32'd2);
        check("post-reset lw data", data, 32'h11223344);
        check("post-reset lw err", 32'(err), 32'd0);

        check("memRead and memWrite together", 32'(both_hi), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
